frame_scan_ctrl: RTL and testbench

Sequencing controller between the incoming pixel stream and the row-FIFO `memory` / `resize` datapath of the face detection system. It accepts pixels under a valid/ready handshake and generates raster coordinates and the FIFO write enable. It tracks how many rows are buffered and flags when a full detection window is available to the Haar classifier. It also reports end of frame and honours downstream backpressure.

---
 rtl/face_detect_pkg.sv | 20 ++
 rtl/scan_coord_counter.sv | 71 +++++++
 rtl/frame_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frame_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_detect_pkg.sv
// ---------------------------------------------------------------------------
// face_detect_pkg
// Shared types and widths for the face detection front end.
//   scan_state_t      : sequencing states of frame_scan_ctrl
//   BYTE_WIDTH        : pixel width
//   BYTE_DOUBLE_WIDTH : coordinate width
// ---------------------------------------------------------------------------
package face_detect_pkg;

    localparam int BYTE_WIDTH        = 8;
    localparam int BYTE_DOUBLE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_t;

endpackage : face_detect_pkg

// File: rtl/scan_coord_counter.sv
// ---------------------------------------------------------------------------
// scan_coord_counter
// Raster x/y counter. x advances on every enabled cycle. It wraps to 0 after
// FRAME_WIDTH-1, and at that point y increments. y wraps to 0 after
// FRAME_HEIGHT-1. The wrap flags are combinational views of the current count,
// so the user can decide what to do with the position about to be consumed.
// Ports:
//   clk, reset_os     : clock and synchronous active-high reset
//   i_clear           : force x=y=0 on the next edge (has priority over i_en)
//   i_en              : advance one raster position
//   o_x, o_y          : current coordinates
//   o_row_end         : x is at FRAME_WIDTH-1
//   o_frame_end       : x,y are at the last pixel of the frame
// ---------------------------------------------------------------------------
module scan_coord_counter #(
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10,
    parameter int COORD_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_os,
    input  logic                   i_clear,
    input  logic                   i_en,
    output logic [COORD_WIDTH-1:0] o_x,
    output logic [COORD_WIDTH-1:0] o_y,
    output logic                   o_row_end,
    output logic                   o_frame_end
);

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);

    logic [COORD_WIDTH-1:0] x_q, x_d;
    logic [COORD_WIDTH-1:0] y_q, y_d;

    assign o_row_end   = (x_q == X_LAST);
    assign o_frame_end = o_row_end && (y_q == Y_LAST);
    assign o_x         = x_q;
    assign o_y         = y_q;

    // NOTE: every variable gets its hold value before any branch; otherwise a
    // path that skips an assignment infers a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_clear) begin
            x_d = '0;
            y_d = '0;
        end else if (i_en) begin
            if (o_row_end) begin
                x_d = '0;
                y_d = o_frame_end ? '0 : y_q + COORD_WIDTH'(1);
            end else begin
                x_d = x_q + COORD_WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that all flops
    // sample their inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_os) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule : scan_coord_counter

// File: rtl/frame_scan_ctrl.sv
// ---------------------------------------------------------------------------
// frame_scan_ctrl
// Controls the sequencing between the pixel stream and the row-FIFO memory /
// resize datapath. It accepts pixels under valid/ready and produces the FIFO
// write, the raster coordinates, the window-complete flag, and the end-of-frame
// pulse.
// Optional build macro: FRAME_SCAN_CTRL_CONTINUOUS_EN. When it is defined,
// DONE goes straight back to FILL, so i_start is needed only once after reset.
// Ports:
//   clk, reset_os       : clock and synchronous active-high reset
//   i_start             : begin a frame (sampled in IDLE only)
//   i_valid, i_pixel    : pixel stream input
//   i_stall             : classifier backpressure
//   o_ready             : combinational, state and i_stall only
//   o_pixel, o_wen      : registered write to the row FIFOs
//   o_xcoord, o_ycoord  : coordinates of o_pixel
//   o_window_valid      : window ending at (o_xcoord,o_ycoord) is complete
//   o_frame_done        : one-cycle pulse after the last pixel's write
//   o_busy              : controller is not IDLE
// If WINDOW_SIZE exceeds either frame dimension, no full window ever exists.
// The controller then stays in FILL for the whole frame. WINDOW_SIZE must be at
// least 2.
// ---------------------------------------------------------------------------
module frame_scan_ctrl #(
    parameter int BYTE_WIDTH        = face_detect_pkg::BYTE_WIDTH,
    parameter int BYTE_DOUBLE_WIDTH = face_detect_pkg::BYTE_DOUBLE_WIDTH,
    parameter int FRAME_WIDTH       = 10,
    parameter int FRAME_HEIGHT      = 10,
    parameter int WINDOW_SIZE       = 6
) (
    input  logic                         clk,
    input  logic                         reset_os,
    input  logic                         i_start,
    input  logic                         i_valid,
    input  logic [BYTE_WIDTH-1:0]        i_pixel,
    input  logic                         i_stall,
    output logic                         o_ready,
    output logic [BYTE_WIDTH-1:0]        o_pixel,
    output logic                         o_wen,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_xcoord,
    output logic [BYTE_DOUBLE_WIDTH-1:0] o_ycoord,
    output logic                         o_window_valid,
    output logic                         o_frame_done,
    output logic                         o_busy
);

    import face_detect_pkg::*;

    localparam int CW = BYTE_DOUBLE_WIDTH;
    localparam bit WINDOW_FITS = (WINDOW_SIZE <= FRAME_WIDTH) && (WINDOW_SIZE <= FRAME_HEIGHT);
    // The window covers WINDOW_SIZE rows. Once row WINDOW_SIZE-2 is buffered,
    // every pixel from row WINDOW_SIZE-1 onward can complete a window.
    localparam logic [CW-1:0] FILL_LAST_ROW = CW'(WINDOW_SIZE - 2);
    localparam logic [CW-1:0] WIN_FIRST_X   = CW'(WINDOW_SIZE - 1);

    scan_state_t             state_q, state_d;
    logic [BYTE_WIDTH-1:0]   pixel_q, pixel_d;
    logic                    wen_q, wen_d;
    logic [CW-1:0]           xcoord_q, xcoord_d;
    logic [CW-1:0]           ycoord_q, ycoord_d;
    logic                    window_valid_q, window_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;

    logic                    accept;
    logic                    cnt_clear;
    logic [CW-1:0]           cnt_x, cnt_y;
    logic                    cnt_row_end, cnt_frame_end;

    assign o_ready = ((state_q == FILL) || (state_q == SCAN)) && !i_stall;
    assign accept  = i_valid && o_ready;

    scan_coord_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .COORD_WIDTH  (CW)
    ) u_coord (
        .clk         (clk),
        .reset_os    (reset_os),
        .i_clear     (cnt_clear),
        .i_en        (accept),
        .o_x         (cnt_x),
        .o_y         (cnt_y),
        .o_row_end   (cnt_row_end),
        .o_frame_end (cnt_frame_end)
    );

    always_comb begin
        state_d        = state_q;
        cnt_clear      = 1'b0;
        pixel_d        = pixel_q;
        wen_d          = 1'b0;
        xcoord_d       = xcoord_q;
        ycoord_d       = ycoord_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = FILL;
                    cnt_clear = 1'b1;
                end
            end
            FILL: begin
                if (accept) begin
                    if (cnt_frame_end) begin
                        state_d = DONE;
                    end else if (WINDOW_FITS && cnt_row_end && (cnt_y == FILL_LAST_ROW)) begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (accept && cnt_frame_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The DONE cycle is visible one cycle later on o_frame_done,
                // which is one cycle after the last pixel's o_wen.
                frame_done_d = 1'b1;
`ifdef FRAME_SCAN_CTRL_CONTINUOUS_EN
                state_d   = FILL;
                cnt_clear = 1'b1;
`else
                state_d   = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Output registers capture the position being consumed. They hold
        // between accepts so that the coordinates stay stable during a stall.
        if (accept) begin
            pixel_d        = i_pixel;
            wen_d          = 1'b1;
            xcoord_d       = cnt_x;
            ycoord_d       = cnt_y;
            window_valid_d = (state_q == SCAN) && (cnt_x >= WIN_FIRST_X);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_os) begin
            state_q        <= IDLE;
            pixel_q        <= '0;
            wen_q          <= 1'b0;
            xcoord_q       <= '0;
            ycoord_q       <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pixel_q        <= pixel_d;
            wen_q          <= wen_d;
            xcoord_q       <= xcoord_d;
            ycoord_q       <= ycoord_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
        end
    end

    assign o_pixel        = pixel_q;
    assign o_wen          = wen_q;
    assign o_xcoord       = xcoord_q;
    assign o_ycoord       = ycoord_q;
    assign o_window_valid = window_valid_q;
    assign o_frame_done   = frame_done_q;
    assign o_busy         = busy_q;

endmodule : frame_scan_ctrl

// File: tb/tb_frame_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_scan_ctrl
// Self-checking bench for frame_scan_ctrl. A frame-level reference model tracks
// the phase (idle/active/done) and the number of accepted pixels. It predicts
// o_ready, and it derives every output coordinate and window flag from the
// pixel index.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_scan_ctrl;

    localparam int FW = 10;
    localparam int FH = 10;
    localparam int WS = 6;
`ifdef FRAME_SCAN_CTRL_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_os;
    logic        i_start, i_valid, i_stall;
    logic [7:0]  i_pixel;
    logic        o_ready, o_wen, o_window_valid, o_frame_done, o_busy;
    logic [7:0]  o_pixel;
    logic [15:0] o_xcoord, o_ycoord;

    always #5 clk = ~clk;

    frame_scan_ctrl #(
        .BYTE_WIDTH        (8),
        .BYTE_DOUBLE_WIDTH (16),
        .FRAME_WIDTH       (FW),
        .FRAME_HEIGHT      (FH),
        .WINDOW_SIZE       (WS)
    ) dut (
        .clk            (clk),
        .reset_os       (reset_os),
        .i_start        (i_start),
        .i_valid        (i_valid),
        .i_pixel        (i_pixel),
        .i_stall        (i_stall),
        .o_ready        (o_ready),
        .o_pixel        (o_pixel),
        .o_wen          (o_wen),
        .o_xcoord       (o_xcoord),
        .o_ycoord       (o_ycoord),
        .o_window_valid (o_window_valid),
        .o_frame_done   (o_frame_done),
        .o_busy         (o_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_ACTIVE, P_DONE} phase_e;
    phase_e ph;
    int     m_n;                 // pixels accepted in the current frame
    int     cur_x, cur_y, cur_px;

    // ---------------- observation tallies ----------------
    int cyc;
    int n_wen, n_win, n_done;
    int first_wx, first_wy;
    int c99, cdone, c00_after;
    bit obs_rdy;

    task automatic clear_tallies();
        n_wen = 0; n_win = 0; n_done = 0;
        first_wx = -1; first_wy = -1;
        c99 = -1; cdone = -1; c00_after = -1;
    endtask

    // Entered just after a rising edge: drive the inputs, check o_ready at the
    // falling edge, advance the model, and check the registered outputs after
    // the next rising edge.
    task automatic step(input bit st, input bit v, input bit sl);
        logic [7:0] px;
        bit exp_rdy, acc, exp_win, exp_done;
        px = 8'($urandom);
        i_start = st; i_valid = v; i_pixel = px; i_stall = sl;
        @(negedge clk);
        obs_rdy = o_ready;
        exp_rdy = (ph == P_ACTIVE) && !sl;
        check("o_ready", int'(o_ready), int'(exp_rdy));
        acc      = exp_rdy && v;
        exp_win  = 1'b0;
        exp_done = (ph == P_DONE);
        if (acc) begin
            cur_x   = m_n % FW;
            cur_y   = m_n / FW;
            cur_px  = int'(px);
            exp_win = (cur_x >= WS - 1) && (cur_y >= WS - 1);
            m_n++;
        end
        case (ph)
            P_IDLE:   if (st) begin ph = P_ACTIVE; m_n = 0; end
            P_ACTIVE: if (m_n == FW * FH) ph = P_DONE;
            default:  begin ph = CONT ? P_ACTIVE : P_IDLE; m_n = 0; end
        endcase
        @(posedge clk); #1;
        cyc++;
        check("o_wen",          int'(o_wen),          int'(acc));
        check("o_pixel",        int'(o_pixel),        cur_px);
        check("o_xcoord",       int'(o_xcoord),       cur_x);
        check("o_ycoord",       int'(o_ycoord),       cur_y);
        check("o_window_valid", int'(o_window_valid), int'(exp_win));
        check("o_frame_done",   int'(o_frame_done),   int'(exp_done));
        check("o_busy",         int'(o_busy),         int'(ph != P_IDLE));
        if (o_wen) begin
            n_wen++;
            if (int'(o_xcoord) == FW - 1 && int'(o_ycoord) == FH - 1 && c99 < 0) c99 = cyc;
            if (o_xcoord == 16'd0 && o_ycoord == 16'd0 && c99 >= 0 && c00_after < 0) c00_after = cyc;
        end
        if (o_window_valid) begin
            n_win++;
            if (first_wx < 0) begin first_wx = int'(o_xcoord); first_wy = int'(o_ycoord); end
        end
        if (o_frame_done) begin
            n_done++;
            cdone = cyc;
        end
    endtask

    task automatic do_reset(input bit v);
        reset_os = 1'b1; i_start = 1'b1; i_valid = v; i_stall = 1'b0; i_pixel = 8'hA5;
        @(posedge clk); #1;
        reset_os = 1'b0; i_start = 1'b0;
        ph = P_IDLE; m_n = 0; cur_x = 0; cur_y = 0; cur_px = 0;
        check("rst_o_wen",          int'(o_wen),          0);
        check("rst_o_pixel",        int'(o_pixel),        0);
        check("rst_o_xcoord",       int'(o_xcoord),       0);
        check("rst_o_ycoord",       int'(o_ycoord),       0);
        check("rst_o_window_valid", int'(o_window_valid), 0);
        check("rst_o_frame_done",   int'(o_frame_done),   0);
        check("rst_o_busy",         int'(o_busy),         0);
        clear_tallies();
    endtask

    // Stream until the model has accepted `target` pixels, then confirm from
    // the DUT that the last written position is pixel target-1.
    task automatic run_until_n(input int target);
        int k = 0;
        while (m_n != target && k < 300) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        check("reach_x", int'(o_xcoord), (target - 1) % FW);
        check("reach_y", int'(o_ycoord), (target - 1) / FW);
    endtask

    task automatic run_to_done();
        int k = 0;
        while (n_done == 0 && k < 300) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        check("frame_done_seen", n_done, 1);
    endtask

    typedef struct {
        bit st, v, sl;
        bit e_rdy, e_wen, e_busy;
        int e_x, e_y;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{0,1,0, 0,0,0, 0,0};   // idle: no ready even with valid
        tbl[1] = '{1,1,0, 0,0,1, 0,0};   // start sampled
        tbl[2] = '{0,1,0, 1,1,1, 0,0};   // first pixel (0,0)
        tbl[3] = '{0,1,1, 0,0,1, 0,0};   // stall: hold
        tbl[4] = '{0,0,0, 1,0,1, 0,0};   // ready but no valid
        tbl[5] = '{0,1,0, 1,1,1, 1,0};
        tbl[6] = '{1,1,0, 1,1,1, 2,0};   // start ignored while busy
        tbl[7] = '{0,1,1, 0,0,1, 2,0};

        cyc = 0;
        reset_os = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_pixel = '0;
        @(posedge clk); #1;

        // Table-driven handshake vectors.
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].sl);
            check($sformatf("tbl%0d_ready", i), int'(obs_rdy),  int'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_wen",   i), int'(o_wen),    int'(tbl[i].e_wen));
            check($sformatf("tbl%0d_busy",  i), int'(o_busy),   int'(tbl[i].e_busy));
            check($sformatf("tbl%0d_x",     i), int'(o_xcoord), tbl[i].e_x);
            check($sformatf("tbl%0d_y",     i), int'(o_ycoord), tbl[i].e_y);
        end

        // Full frame at full rate.
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_to_done();
        check("frame_wen_count", n_wen, FW * FH);
        check("frame_win_count", n_win, (FW - WS + 1) * (FH - WS + 1));
        check("first_win_x", first_wx, WS - 1);
        check("first_win_y", first_wy, WS - 1);
        check("done_after_last", cdone - c99, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Three-cycle stall at pixel (3,2).
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_until_n(2 * FW + 3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("stall_ready", int'(obs_rdy), 0);
            check("stall_wen",   int'(o_wen), 0);
            check("stall_x",     int'(o_xcoord), 2);
            check("stall_y",     int'(o_ycoord), 2);
        end
        step(1'b0, 1'b1, 1'b0);
        check("resume_x", int'(o_xcoord), 3);
        check("resume_y", int'(o_ycoord), 2);
        run_to_done();
        check("stall_wen_count", n_wen, FW * FH);

        // Reset at pixel (4,7), then restart.
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_until_n(7 * FW + 4);
        do_reset(1'b1);
        step(1'b0, 1'b1, 1'b0);          // IDLE: nothing accepted
        check("post_rst_wen", int'(o_wen), 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("restart_wen", int'(o_wen), 1);
        check("restart_x",   int'(o_xcoord), 0);
        check("restart_y",   int'(o_ycoord), 0);

        // i_start at (2,2) is ignored.
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_until_n(2 * FW + 2);
        step(1'b1, 1'b1, 1'b0);
        run_to_done();
        check("midstart_wen_count", n_wen, FW * FH);

        // Random valid/stall/start against the model.
        do_reset(1'b0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0);
        end
        check("rand_frames_seen", int'(n_done >= 2), 1);

`ifdef FRAME_SCAN_CTRL_CONTINUOUS_EN
        // Back-to-back frames from a single start.
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 500 && n_done < 2; k++) begin
            step(1'b0, 1'b1, 1'b0);
        end
        check("cont_done_count", n_done, 2);
        check("cont_wen_count",  n_wen, 2 * FW * FH);
        check("cont_gap",        c00_after - c99, 2);
`else
        // Single-frame mode: nothing is accepted after DONE without a new start.
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_to_done();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        check("idle_after_done_wen", n_wen, FW * FH);
        check("idle_after_done_busy", int'(o_busy), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_frame_scan_ctrl
